// File: rtl/regression_accumulator_if.sv
// Sample-stream and result bundle between the sample loader, the
// regression accumulator and the coefficient stage.
interface regression_accumulator_if #(
    parameter int DW = 20,
    parameter int CW = 8
);
    logic                       start;
    logic                       sample_valid;
    logic                       sample_last;
    logic signed [DW-1:0]       xi;
    logic signed [DW-1:0]       yi;
    logic                       busy;
    logic                       done;
    logic                       result_valid;
    logic [CW-1:0]              count;
    logic signed [DW+CW-1:0]    sum_x;
    logic signed [DW+CW-1:0]    sum_y;
    logic signed [2*DW+CW-1:0]  sum_xx;
    logic signed [2*DW+CW-1:0]  sum_xy;
    logic                       ovf;

    modport master (
        output start, sample_valid, sample_last, xi, yi,
        input  busy, done, result_valid, count, sum_x, sum_y, sum_xx, sum_xy, ovf
    );

    modport slave (
        input  start, sample_valid, sample_last, xi, yi,
        output busy, done, result_valid, count, sum_x, sum_y, sum_xx, sum_xy, ovf
    );
endinterface

// File: rtl/regression_accumulator.sv
// Accumulates count, sum_x, sum_y, sum_xx and sum_xy over a framed run of signed
// (xi, yi) samples for the regression-coefficient stage.
//   state | meaning
//   IDLE  | results held, waiting for start
//   ACC   | accepting samples until the last one
//   DRAIN | last sample still travelling through the pipeline
//   DONE  | one-cycle done pulse, results final
module regression_accumulator #(
    parameter int DW = 20,
    parameter int CW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    regression_accumulator_if.slave  acc_if
);
    localparam int SW = DW + CW;
    localparam int PW = 2 * DW + CW;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t state_q;
    logic   busy_q, done_q, result_valid_q;

    logic accept, start_ok;
    assign accept   = (state_q == ACC) && acc_if.sample_valid;
    assign start_ok = (state_q == IDLE) && acc_if.start;

    logic                 in_valid_q, in_last_q;
    logic signed [DW-1:0] in_x_q, in_y_q;

    logic                 s1_valid_q, s1_last_q;
    logic signed [SW-1:0] s1_x_q, s1_y_q;
    logic signed [PW-1:0] s1_xx_q, s1_xy_q;

    logic [CW-1:0]        count_q;
    logic signed [SW-1:0] sum_x_q, sum_y_q;
    logic signed [PW-1:0] sum_xx_q, sum_xy_q;
    logic                 ovf_q;

    logic signed [2*DW-1:0] x_w, y_w, prod_xx, prod_xy;
    assign x_w     = (2*DW)'(in_x_q);
    assign y_w     = (2*DW)'(in_y_q);
    assign prod_xx = x_w * x_w;
    assign prod_xy = x_w * y_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (acc_if.start) begin
                        state_q        <= ACC;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept && acc_if.sample_last) state_q <= DRAIN;
                end
                DRAIN: begin
                    // The last sample lands in the accumulators on this same edge.
                    if (s1_valid_q && s1_last_q) begin
                        state_q        <= DONE;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        result_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_valid_q <= 1'b0;
            in_last_q  <= 1'b0;
            in_x_q     <= '0;
            in_y_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_xx_q    <= '0;
            s1_xy_q    <= '0;
            count_q    <= '0;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            sum_xx_q   <= '0;
            sum_xy_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            in_valid_q <= accept;
            in_last_q  <= accept && acc_if.sample_last;
            if (accept) begin
                in_x_q <= acc_if.xi;
                in_y_q <= acc_if.yi;
            end

            s1_valid_q <= in_valid_q;
            s1_last_q  <= in_last_q;
            if (in_valid_q) begin
                s1_x_q  <= SW'(in_x_q);
                s1_y_q  <= SW'(in_y_q);
                s1_xx_q <= PW'(prod_xx);
                s1_xy_q <= PW'(prod_xy);
            end

            if (start_ok) begin
                count_q  <= '0;
                sum_x_q  <= '0;
                sum_y_q  <= '0;
                sum_xx_q <= '0;
                sum_xy_q <= '0;
                ovf_q    <= 1'b0;
            end else if (s1_valid_q) begin
                count_q  <= count_q + CW'(1);
                if (&count_q) ovf_q <= 1'b1;
                sum_x_q  <= sum_x_q + s1_x_q;
                sum_y_q  <= sum_y_q + s1_y_q;
                sum_xx_q <= sum_xx_q + s1_xx_q;
                sum_xy_q <= sum_xy_q + s1_xy_q;
            end
        end
    end

    assign acc_if.busy         = busy_q;
    assign acc_if.done         = done_q;
    assign acc_if.result_valid = result_valid_q;
    assign acc_if.count        = count_q;
    assign acc_if.sum_x        = sum_x_q;
    assign acc_if.sum_y        = sum_y_q;
    assign acc_if.sum_xx       = sum_xx_q;
    assign acc_if.sum_xy       = sum_xy_q;
    assign acc_if.ovf          = ovf_q;
endmodule

// File: tb/tb_regression_accumulator.sv
// Bench for regression_accumulator: a CW=8 and a CW=2 instance share one stimulus
// stream and are compared against an arithmetic model of the run statistics.
module tb_regression_accumulator;
    localparam int DW = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regression_accumulator_if #(.DW(DW), .CW(8)) a ();
    regression_accumulator_if #(.DW(DW), .CW(2)) b ();

    assign b.start        = a.start;
    assign b.sample_valid = a.sample_valid;
    assign b.sample_last  = a.sample_last;
    assign b.xi           = a.xi;
    assign b.yi           = a.yi;

    regression_accumulator #(.DW(DW), .CW(8)) dut_a (.clk(clk), .rst(rst_n), .acc_if(a));
    regression_accumulator #(.DW(DW), .CW(2)) dut_b (.clk(clk), .rst(rst_n), .acc_if(b));

    typedef struct packed {
        longint cnt;
        longint sx;
        longint sy;
        longint sxx;
        longint sxy;
        logic   ovf;
        logic   rv;
    } stats_t;

    int errors = 0;
    int checks = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int sx[$];
    int sy[$];

    always @(negedge clk) begin
        if (a.done) done_cnt_a++;
        if (b.done) done_cnt_b++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    // Statistics a run over the queued samples should leave behind.
    function automatic stats_t model(input int cw);
        stats_t e;
        longint tx = 0, ty = 0, txx = 0, txy = 0;
        foreach (sx[i]) begin
            tx  += longint'(sx[i]);
            ty  += longint'(sy[i]);
            txx += longint'(sx[i]) * longint'(sx[i]);
            txy += longint'(sx[i]) * longint'(sy[i]);
        end
        e.cnt = longint'(sx.size() % (1 << cw));
        e.sx  = wrap(tx, DW + cw);
        e.sy  = wrap(ty, DW + cw);
        e.sxx = wrap(txx, 2 * DW + cw);
        e.sxy = wrap(txy, 2 * DW + cw);
        e.ovf = (sx.size() >= (1 << cw));
        e.rv  = 1'b1;
        return e;
    endfunction

    function automatic stats_t obs_a();
        stats_t o;
        o.cnt = longint'(a.count);
        o.sx  = longint'(a.sum_x);
        o.sy  = longint'(a.sum_y);
        o.sxx = longint'(a.sum_xx);
        o.sxy = longint'(a.sum_xy);
        o.ovf = a.ovf;
        o.rv  = a.result_valid;
        return o;
    endfunction

    function automatic stats_t obs_b();
        stats_t o;
        o.cnt = longint'(b.count);
        o.sx  = longint'(b.sum_x);
        o.sy  = longint'(b.sum_y);
        o.sxx = longint'(b.sum_xx);
        o.sxy = longint'(b.sum_xy);
        o.ovf = b.ovf;
        o.rv  = b.result_valid;
        return o;
    endfunction

    function automatic string fmt(input stats_t s);
        return $sformatf("cnt=%0d sx=%0d sy=%0d sxx=%0d sxy=%0d ovf=%0b rv=%0b",
                         s.cnt, s.sx, s.sy, s.sxx, s.sxy, s.ovf, s.rv);
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, 20'hFFFFF)) - 524288;
    endfunction

    // Drives start, the queued samples with 'gap' idle cycles before each one,
    // then waits for done. With 'poke', spurious start/sample_last are injected
    // in ACC gaps and on the first DRAIN cycle.
    task automatic run_q(input int gap, input bit poke, output int lat, output int pulses);
        int d0;
        d0 = done_cnt_a;
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        foreach (sx[i]) begin
            for (int g = 0; g < gap; g++) begin
                a.sample_valid = 1'b0;
                a.sample_last  = poke;
                a.start        = poke;
                a.xi           = DW'(rnd_sample());
                a.yi           = DW'(rnd_sample());
                step();
                a.start       = 1'b0;
                a.sample_last = 1'b0;
            end
            a.sample_valid = 1'b1;
            a.xi           = DW'(sx[i]);
            a.yi           = DW'(sy[i]);
            a.sample_last  = (i == sx.size() - 1);
            step();
        end
        a.sample_valid = 1'b0;
        a.sample_last  = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            if (poke && k == 1) a.start = 1'b1;
            step();
            a.start = 1'b0;
            if (a.done) begin
                lat = k;
                break;
            end
        end
        step();
        step();
        pulses = done_cnt_a - d0;
    endtask

    task automatic load_basic();
        sx = {1, 2, 3};
        sy = {2, 4, 6};
    endtask

    task automatic test_reset();
        stats_t o;
        #2;
        o = obs_a();
        checks++;
        if (o !== stats_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %s want all zero", fmt(o));
        end
        checks++;
        if (a.busy !== 1'b0 || a.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%0b done=%0b want 0 0", a.busy, a.done);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        stats_t e, o;
        int lat, pulses;
        load_basic();
        run_q(0, 1'b0, lat, pulses);
        e = model(8);
        o = obs_a();
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL basic_done_latency: got %0d edges after accept edge, want 2", lat);
        end
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL basic_results: got %s want %s", fmt(o), fmt(e));
        end
        checks++;
        if (a.sum_xx !== 48'sd14 || a.sum_xy !== 48'sd28 || a.count !== 8'd3) begin
            errors++;
            $display("FAIL basic_constants: got sxx=%0d sxy=%0d cnt=%0d want 14 28 3",
                     a.sum_xx, a.sum_xy, a.count);
        end
        checks++;
        if (a.done !== 1'b0 || a.busy !== 1'b0 || pulses !== 1) begin
            errors++;
            $display("FAIL basic_after_done: done=%0b busy=%0b pulses=%0d want 0 0 1",
                     a.done, a.busy, pulses);
        end
    endtask

    task automatic test_signed();
        stats_t e, o;
        int lat, pulses;
        sx = {-1, -2};
        sy = {3, -5};
        run_q(0, 1'b0, lat, pulses);
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL signed_results: got %s want %s", fmt(o), fmt(e));
        end
        checks++;
        if (a.sum_x !== -28'sd3 || a.sum_y !== -28'sd2 || a.sum_xx !== 48'sd5 || a.sum_xy !== 48'sd7) begin
            errors++;
            $display("FAIL signed_constants: got sx=%0d sy=%0d sxx=%0d sxy=%0d want -3 -2 5 7",
                     a.sum_x, a.sum_y, a.sum_xx, a.sum_xy);
        end
    endtask

    task automatic test_bubbles();
        stats_t e, o;
        int lat, pulses;
        a.sample_valid = 1'b1;
        a.sample_last  = 1'b1;
        a.xi = DW'(77);
        a.yi = DW'(-9);
        step();
        step();
        a.sample_valid = 1'b0;
        a.sample_last  = 1'b0;
        load_basic();
        run_q(2, 1'b0, lat, pulses);
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e || lat !== 2) begin
            errors++;
            $display("FAIL bubbles_results: got %s lat=%0d want %s lat=2", fmt(o), lat, fmt(e));
        end
        // sample_last without sample_valid during the gaps must not end the run
        run_q(1, 1'b1, lat, pulses);
        o = obs_a();
        checks++;
        if (o !== e || pulses !== 1) begin
            errors++;
            $display("FAIL bubbles_stray_last: got %s pulses=%0d want %s pulses=1", fmt(o), pulses, fmt(e));
        end
    endtask

    task automatic test_start_busy();
        stats_t e, o;
        int lat, pulses;
        load_basic();
        run_q(1, 1'b1, lat, pulses);
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e || lat !== 2 || pulses !== 1) begin
            errors++;
            $display("FAIL start_busy_run: got %s lat=%0d pulses=%0d want %s lat=2 pulses=1",
                     fmt(o), lat, pulses, fmt(e));
        end
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        o = obs_a();
        checks++;
        if (o !== stats_t'(0) || a.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears: got %s busy=%0b want all zero busy=1", fmt(o), a.busy);
        end
        sx = {7};
        sy = {-3};
        a.sample_valid = 1'b1;
        a.sample_last  = 1'b1;
        a.xi = DW'(7);
        a.yi = DW'(-3);
        step();
        a.sample_valid = 1'b0;
        a.sample_last  = 1'b0;
        for (int k = 0; k < 4; k++) step();
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL single_sample_run: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_overflow();
        stats_t e, o;
        int lat, pulses, db;
        db = done_cnt_b;
        sx = {1, 1, 1, 1, 1};
        sy = {1, 1, 1, 1, 1};
        run_q(0, 1'b0, lat, pulses);
        e = model(2);
        o = obs_b();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ovf_cw2: got %s want %s", fmt(o), fmt(e));
        end
        checks++;
        if (b.count !== 2'd1 || b.ovf !== 1'b1 || b.sum_x !== 22'sd5 || b.sum_xx !== 42'sd5 || done_cnt_b - db !== 1) begin
            errors++;
            $display("FAIL ovf_constants: got cnt=%0d ovf=%0b sx=%0d sxx=%0d done=%0d want 1 1 5 5 1",
                     b.count, b.ovf, b.sum_x, b.sum_xx, done_cnt_b - db);
        end
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ovf_cw8_no_wrap: got %s want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_reset_mid_run();
        stats_t e, o;
        int d0, lat, pulses;
        d0 = done_cnt_a;
        a.start = 1'b1;
        step();
        a.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a.sample_valid = 1'b1;
            a.sample_last  = 1'b0;
            a.xi = DW'(i + 5);
            a.yi = DW'(i - 8);
            step();
        end
        step();
        #3;
        rst_n = 1'b0;
        a.sample_valid = 1'b0;
        #1;
        o = obs_a();
        checks++;
        if (o !== stats_t'(0) || a.busy !== 1'b0 || a.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got %s busy=%0b done=%0b want all zero", fmt(o), a.busy, a.done);
        end
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (done_cnt_a !== d0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", done_cnt_a - d0);
        end
        load_basic();
        run_q(0, 1'b0, lat, pulses);
        e = model(8);
        o = obs_a();
        checks++;
        if (o !== e || lat !== 2) begin
            errors++;
            $display("FAIL reset_rerun: got %s lat=%0d want %s lat=2", fmt(o), lat, fmt(e));
        end
    endtask

    task automatic test_random();
        stats_t ea, oa, eb, ob;
        int lat, pulses, n, gap;
        for (int r = 0; r < 7; r++) begin
            n   = (r == 6) ? 260 : int'($urandom_range(1, 8));
            gap = (r == 6) ? 0 : int'($urandom_range(0, 3));
            sx = {};
            sy = {};
            for (int i = 0; i < n; i++) begin
                sx.push_back(rnd_sample());
                sy.push_back(rnd_sample());
            end
            run_q(gap, r[0], lat, pulses);
            ea = model(8);
            eb = model(2);
            oa = obs_a();
            ob = obs_b();
            checks++;
            if (oa !== ea || lat !== 2 || pulses !== 1) begin
                errors++;
                $display("FAIL random_cw8 run %0d n=%0d: got %s lat=%0d pulses=%0d want %s",
                         r, n, fmt(oa), lat, pulses, fmt(ea));
            end
            checks++;
            if (ob !== eb) begin
                errors++;
                $display("FAIL random_cw2 run %0d n=%0d: got %s want %s", r, n, fmt(ob), fmt(eb));
            end
        end
    endtask

    initial begin
        a.start        = 1'b0;
        a.sample_valid = 1'b0;
        a.sample_last  = 1'b0;
        a.xi           = '0;
        a.yi           = '0;
        test_reset();
        test_basic();
        test_signed();
        test_bubbles();
        test_start_busy();
        test_overflow();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
